// File: rtl/complex_result_buffer_pkg.sv
// Shared complex-multiplier types and helpers used by the result buffer and its bench.
package complex_mult_pkg;

    localparam int unsigned CM_WIDTH = 8;
    localparam int unsigned CM_RES_W = 2 * CM_WIDTH;

    typedef struct packed {
        logic [CM_WIDTH-1:0] re;
        logic [CM_WIDTH-1:0] im;
    } cm_result_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned cm_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (value > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/complex_result_buffer_if.sv
// Producer/consumer bus of the complex result buffer.
// RESBUF_DROPCNT_EN adds the saturating dropCnt signal.
interface complex_result_buffer_if
    import complex_mult_pkg::*;
#(
    parameter int unsigned WIDTH = CM_WIDTH,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LVL_W = cm_clog2(DEPTH) + 1;

    logic                 resDone;
    logic [2*WIDTH-1:0]   res;
    logic                 clr;
    logic                 outReady;
    logic                 outValid;
    logic [2*WIDTH-1:0]   outData;
    logic                 full;
    logic [LVL_W-1:0]     level;
    logic                 overflow;
`ifdef RESBUF_DROPCNT_EN
    logic [7:0]           dropCnt;
`endif

    modport master (
        output resDone, res, clr, outReady,
`ifdef RESBUF_DROPCNT_EN
        input  dropCnt,
`endif
        input  outValid, outData, full, level, overflow
    );

    modport slave (
        input  resDone, res, clr, outReady,
`ifdef RESBUF_DROPCNT_EN
        output dropCnt,
`endif
        output outValid, outData, full, level, overflow
    );

endinterface

// File: rtl/complex_result_buffer_ptr.sv
// Wrapping FIFO pointer register with synchronous clear (priority) and advance enable.
module resbuf_ptr #(
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/complex_result_buffer.sv
// First-word-fall-through result FIFO between the complex multiplier and its consumer.
// Defining RESBUF_DROPCNT_EN adds a saturating count of dropped pushes (dropCnt).
module complex_result_buffer
    import complex_mult_pkg::*;
#(
    parameter int unsigned WIDTH = CM_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    complex_result_buffer_if.slave bus
);

    localparam int unsigned PTR_W = cm_clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DW    = 2 * WIDTH;

    logic             push, pop, drop;
    logic             out_valid, full;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [DW-1:0]    mem_q [DEPTH];

    always_comb begin
        out_valid = (level_q != '0);
        full      = (level_q == LVL_W'(DEPTH));
        pop       = out_valid & bus.outReady;
        // A pop on a full buffer frees the slot the concurrent push lands in.
        push      = bus.resDone & (~full | pop);
        drop      = bus.resDone & ~push;
    end

    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        if (bus.clr) begin
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
            overflow_d = overflow_q | drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push && !bus.clr) begin
            mem_q[wr_ptr] <= bus.res;
        end
    end

    resbuf_ptr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push),
        .clr_i (bus.clr),
        .ptr_o (wr_ptr)
    );

    resbuf_ptr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop),
        .clr_i (bus.clr),
        .ptr_o (rd_ptr)
    );

`ifdef RESBUF_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clr) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.dropCnt = drop_cnt_q;
`endif

    assign bus.outValid = out_valid;
    assign bus.outData  = out_valid ? mem_q[rd_ptr] : '0;
    assign bus.full     = full;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

endmodule
